// File: rtl/jk_sync_up_counter_pkg.sv
// Shared constants and parameter validation for the JK-based synchronous up counter.
package jk_sync_up_counter_pkg;

    localparam int unsigned DefaultWidth   = 4;
    localparam int unsigned DefaultModulus = 16;

    // True when WIDTH is 2..16 and MODULUS is 2..2^WIDTH.
    function automatic bit params_valid(input int unsigned width, input int unsigned modulus);
        return (width >= 2) && (width <= 16) && (modulus >= 2) && (modulus <= (32'd1 << width));
    endfunction

endpackage

// File: rtl/jk_ff_arn.sv
// Single JK flip-flop with asynchronous active-low reset to 0.
module jk_ff_arn (
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= 1'b0;
        end else begin
            unique case ({j, k})
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

endmodule

// File: rtl/jk_sync_up_counter.sv
// Modulo-MODULUS synchronous up counter built from per-bit JK cells, with enable,
// parallel load, cascade terminal count and registered wrap / load-error pulses.
module jk_sync_up_counter
    import jk_sync_up_counter_pkg::*;
#(
    parameter int unsigned WIDTH   = DefaultWidth,
    parameter int unsigned MODULUS = DefaultModulus
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);

    if (!params_valid(WIDTH, MODULUS)) begin : g_bad_params
        $error("jk_sync_up_counter: need 2<=WIDTH<=16 and 2<=MODULUS<=2^WIDTH");
    end

    localparam logic [WIDTH-1:0] MaxCount = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] j, k;
    logic [WIDTH-1:0] carry;
    logic             at_max;
    logic             wrap_d, wrap_q;
    logic             load_err_d, load_err_q;

    assign at_max = (q == MaxCount);
    // Cascade path stays combinational so chained stages advance on the same edge.
    assign tc     = en & at_max;

    always_comb begin
        carry[0] = 1'b1;
        for (int i = 1; i < int'(WIDTH); i++) begin
            carry[i] = carry[i-1] & q[i-1];
        end
    end

    always_comb begin
        j          = '0;
        k          = '0;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (load) begin
            if (32'(d) >= MODULUS) begin
                k          = '1;
                load_err_d = 1'b1;
            end else begin
                j = d;
                k = ~d;
            end
        end else if (en) begin
            if (at_max) begin
                // Explicit clear rather than rollover, so non-power-of-2 moduli wrap correctly.
                k      = '1;
                wrap_d = 1'b1;
            end else begin
                j = carry;
                k = carry;
            end
        end
    end

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        jk_ff_arn u_cell (
            .clk   (clk),
            .reset (reset),
            .j     (j[i]),
            .k     (k[i]),
            .q     (q[i])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign wrap     = wrap_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_jk_sync_up_counter.sv
// Directed self-checking bench for jk_sync_up_counter at moduli 16, 10 and 2.
module tb_jk_sync_up_counter;

    logic       clk = 1'b0;
    logic       reset;

    logic       en16, load16, tc16, wrap16, lerr16;
    logic [3:0] d16, q16;
    logic       en10, load10, tc10, wrap10, lerr10;
    logic [3:0] d10, q10;
    logic       en2, load2, tc2, wrap2, lerr2;
    logic [1:0] d2, q2;

    int n_checks = 0;
    int n_fail   = 0;
    int n_wraps;

    always #5 clk = ~clk;

    jk_sync_up_counter #(.WIDTH(4), .MODULUS(16)) u_dut16 (
        .clk(clk), .reset(reset), .en(en16), .load(load16), .d(d16),
        .q(q16), .tc(tc16), .wrap(wrap16), .load_err(lerr16)
    );

    jk_sync_up_counter #(.WIDTH(4), .MODULUS(10)) u_dut10 (
        .clk(clk), .reset(reset), .en(en10), .load(load10), .d(d10),
        .q(q10), .tc(tc10), .wrap(wrap10), .load_err(lerr10)
    );

    jk_sync_up_counter #(.WIDTH(2), .MODULUS(2)) u_dut2 (
        .clk(clk), .reset(reset), .en(en2), .load(load2), .d(d2),
        .q(q2), .tc(tc2), .wrap(wrap2), .load_err(lerr2)
    );

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset  = 1'b0;
        en16 = 0; load16 = 0; d16 = '0;
        en10 = 0; load10 = 0; d10 = '0;
        en2  = 0; load2  = 0; d2  = '0;

        // Reset state
        #3;
        check("rst_q16", q16, 0);
        check("rst_wrap16", wrap16, 0);
        check("rst_lerr16", lerr16, 0);
        check("rst_q10", q10, 0);
        check("rst_q2", q2, 0);
        @(negedge clk);
        reset = 1'b1;

        // MODULUS=16 full cycle
        en16 = 1;
        #1;
        check("m16_tc_q0", tc16, 0);
        for (int i = 1; i <= 17; i++) begin
            step();
            check($sformatf("m16_q_%0d", i), q16, i % 16);
            check($sformatf("m16_tc_%0d", i), tc16, (i % 16 == 15) ? 1 : 0);
            check($sformatf("m16_wrap_%0d", i), wrap16, (i == 16) ? 1 : 0);
        end
        en16 = 0;
        #1;
        check("m16_hold_tc", tc16, 0);

        // Enable toggling from q=3
        load16 = 1; d16 = 4'd3;
        step();
        check("m16_load3", q16, 3);
        load16 = 0; en16 = 1;
        step();
        check("m16_en1", q16, 4);
        en16 = 0;
        step();
        check("m16_en0", q16, 4);
        en16 = 1;
        step();
        check("m16_en1b", q16, 5);

        // tc gated by en at terminal count
        en16 = 0; load16 = 1; d16 = 4'd15;
        step();
        load16 = 0;
        #1;
        check("m16_q15", q16, 15);
        check("m16_tc_en0", tc16, 0);
        en16 = 1;
        #1;
        check("m16_tc_en1", tc16, 1);

        // load beats en at terminal count; no wrap
        load16 = 1; d16 = 4'd5;
        #1;
        check("m16_tc_ldpri", tc16, 1);
        step();
        check("m16_ldpri_q", q16, 5);
        check("m16_ldpri_wrap", wrap16, 0);
        load16 = 0; en16 = 0;

        // MODULUS=10 counting
        n_wraps = 0;
        en10 = 1;
        for (int i = 1; i <= 20; i++) begin
            step();
            check($sformatf("m10_q_%0d", i), q10, i % 10);
            check($sformatf("m10_tc_%0d", i), tc10, (i % 10 == 9) ? 1 : 0);
            check($sformatf("m10_wrap_%0d", i), wrap10, (i % 10 == 0) ? 1 : 0);
            if (wrap10) n_wraps++;
        end
        check("m10_wrap_count", n_wraps, 2);

        // MODULUS=10 loads
        load10 = 1; d10 = 4'd7;
        step();
        check("m10_ld7_q", q10, 7);
        check("m10_ld7_err", lerr10, 0);
        d10 = 4'd12;
        step();
        check("m10_ld12_q", q10, 0);
        check("m10_ld12_err", lerr10, 1);
        check("m10_ld12_wrap", wrap10, 0);
        d10 = 4'd13;
        step();
        check("m10_ld13_q", q10, 0);
        check("m10_ld13_err", lerr10, 1);
        load10 = 0; en10 = 0;
        step();
        check("m10_err_fall", lerr10, 0);
        check("m10_hold_q", q10, 0);

        // Reset mid-cycle with pulses in flight
        load10 = 1; d10 = 4'd9;
        load16 = 1; d16 = 4'd6;
        step();
        load10 = 0; en10 = 1;
        load16 = 0;
        load2  = 1; d2 = 2'd3;
        step();
        check("pre_rst_q16", q16, 6);
        check("pre_rst_wrap10", wrap10, 1);
        check("pre_rst_lerr2", lerr2, 1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_q16", q16, 0);
        check("mid_rst_wrap10", wrap10, 0);
        check("mid_rst_lerr2", lerr2, 0);
        check("mid_rst_q10", q10, 0);
        #2;
        reset = 1'b1;
        en10 = 0; load2 = 0; d2 = '0;
        en16 = 1;
        step();
        check("post_rst_q16", q16, 1);
        check("post_rst_q10", q10, 0);
        en16 = 0;

        // MODULUS=2 back-to-back wraps
        en2 = 1;
        for (int i = 1; i <= 8; i++) begin
            step();
            check($sformatf("m2_q_%0d", i), q2, i % 2);
            check($sformatf("m2_tc_%0d", i), tc2, i % 2);
            check($sformatf("m2_wrap_%0d", i), wrap2, (i % 2 == 0) ? 1 : 0);
        end
        en2 = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/jk_sync_up_counter.md
# jk_sync_up_counter

Parameterised synchronous up counter built from per-bit JK flip-flop cells: the up-counting counterpart to the team's 2-bit JK down counter. It counts 0 to MODULUS-1 and wraps. It adds enable, synchronous parallel load, a terminal-count output for cascading and a registered wrap pulse. It sits beside the down counter as the default up-count/timebase primitive, and stages can be chained through `tc` into the next stage's `en`.

## Interface
- WIDTH, 4, counter width in bits (2..16)
- MODULUS, 16, count range; the counter wraps after MODULUS-1 (2..2^WIDTH)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; clears all state
- en  in  1  count enable; advance by one on this edge when high
- load  in  1  synchronous parallel load; priority over en
- d  in  WIDTH  load value
- q  out  WIDTH  current count
- tc  out  1  terminal count, combinational: en & (q == MODULUS-1)
- wrap  out  1  registered one-cycle pulse; high in the cycle after q wrapped MODULUS-1 -> 0
- load_err  out  1  registered one-cycle pulse; high in the cycle after a load with d >= MODULUS

## Operation
- Every bit of q is one JK cell. Next-state logic drives J/K per bit, never q directly:
  - Count: bit i toggles (J=K=1) when en and bits [i-1:0] are all 1. Otherwise J=K=0.
  - Wrap at MODULUS-1 with en: every bit is driven to 0 (J=0, K=1). This is required for non-power-of-2 MODULUS.
  - Load: J=d[i], K=~d[i].
  - Hold: J=K=0.
- Priority per edge: reset (async) > load > en > hold.
- Load with d < MODULUS: q <= d, load_err stays low.
- Load with d >= MODULUS: q <= 0, load_err pulses for one cycle, wrap stays low.
- Load never generates wrap, even when q was MODULUS-1 and en was high.
- en low: q holds, and tc is low regardless of q.
- tc is purely combinational from en and q. No flop sits in the cascade path.
- Count arithmetic is modulo MODULUS. q never holds a value >= MODULUS.

## Timing
- Reset asserted (reset=0) forces q=0, wrap=0, load_err=0 immediately, independent of clk.
- Reset release is synchronous-safe: the first count occurs on the first rising clk edge with reset=1 and en=1.
- Latency: q updates on the same edge that samples en/load. wrap and load_err rise on that edge and fall on the next.
- Consecutive wraps (MODULUS=2, en held high) produce wrap high every other cycle. Consecutive invalid loads keep load_err high continuously.
- Reset mid-count discards the count. A wrap or load_err pulse in flight is cleared immediately.
- load and en both high: load wins, no increment, tc still reflects en & (q==MODULUS-1) before the edge.

## Structure
- Shared package/header holds:
  - default WIDTH and MODULUS constants
  - a compile-time check of 2 <= MODULUS <= 2^WIDTH; an out-of-range parameter is an elaboration error
- One sub-module: `jk_ff_arn`, a single JK flip-flop with asynchronous active-low reset to 0. Behaviour: J/K = 00 hold, 01 reset, 10 set, 11 toggle.
  - The counter instantiates WIDTH of these via generate.
  - wrap and load_err are plain flops in the top level.
- The top level contains only J/K derivation, tc decode and the two pulse flops.

## Test plan
- Reset release, en=1, WIDTH=4, MODULUS=16: q steps 0,1,...,15,0. tc high only while q=15. wrap high exactly one cycle after q=0 reappears.
- MODULUS=10: q runs 0..9,0. tc high at q=9. wrap pulses once per 10 cycles. q never shows 10..15.
- en toggling 1,0,1 from q=3: q reads 4, 4, 5. tc stays low when en=0 at q=MODULUS-1.
- MODULUS=10, load=1, d=7, en=1: next q=7, no increment. Then d=12 with load: q=0, load_err pulses one cycle, wrap stays low.
- Reset pulled low between edges at q=6 with wrap high: q, wrap and load_err go to 0 before the next edge. Counting resumes from 0 after release.
- MODULUS=2, en held high: q alternates 0,1. wrap high on every cycle where q=0 after the first wrap.
